// File: rtl/multi_channel_rate_limiter_pkg.sv
// Shared definitions for multi_channel_rate_limiter: state encoding, default
// parameters and throttle curve constants (used when THROTTLE_CURVE_EN is defined).
package multi_channel_rate_limiter_pkg;

    localparam int DEF_WIDTH          = 8;
    localparam int DEF_DEPTH          = 8;
    localparam int DEF_CHANNELS       = 4;
    localparam int DEF_MAX_STEP       = 16;
    localparam int DEF_IDLE_THRESHOLD = 10;

    // Piecewise curve: 2x below LO, x/2 + MID between LO and HI, 2x - HI_OFS above HI
    localparam int CURVE_BP_LO   = 42;
    localparam int CURVE_BP_HI   = 209;
    localparam int CURVE_OFS_MID = 61;
    localparam int CURVE_OFS_HI  = 252;

    typedef enum logic [4:0] {
        WAITING  = 5'b00001,
        LATCH    = 5'b00010,
        ACCUM    = 5'b00100,
        SHAPE    = 5'b01000,
        COMPLETE = 5'b10000
    } state_t;

endpackage

// File: rtl/multi_channel_rate_limiter_shaper.sv
// rate_limit_shaper: combinational avg -> optional curve -> slew limit for one channel.
// Curve stage is present only when THROTTLE_CURVE_EN is defined.
module rate_limit_shaper
    import multi_channel_rate_limiter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int MAX_STEP = DEF_MAX_STEP
) (
    input  logic [WIDTH+$clog2(DEPTH)-1:0] i_sum,
    input  logic [WIDTH-1:0]               i_prev,
    input  logic                           i_idle,
    output logic [WIDTH-1:0]               o_value
);

    localparam int LOG2D = $clog2(DEPTH);
    localparam int EXT_W = WIDTH + 2;
    localparam logic [EXT_W-1:0] MAX_STEP_EXT = EXT_W'(MAX_STEP);

    logic [WIDTH-1:0] w_avg;
    logic [WIDTH-1:0] w_target;
    logic [EXT_W-1:0] w_prev_ext;
    logic [EXT_W-1:0] w_target_ext;
    logic [EXT_W-1:0] w_up;
    logic [EXT_W-1:0] w_dn;

    assign w_avg = WIDTH'(i_sum >> LOG2D);

`ifdef THROTTLE_CURVE_EN
    localparam logic [EXT_W-1:0] MAX_VAL = EXT_W'((1 << WIDTH) - 1);

    logic [EXT_W-1:0] w_avg_ext;
    logic [EXT_W-1:0] w_curve;

    assign w_avg_ext = EXT_W'(w_avg);

    always_comb begin
        if (w_avg_ext < EXT_W'(CURVE_BP_LO))
            w_curve = w_avg_ext << 1;
        else if (w_avg_ext <= EXT_W'(CURVE_BP_HI))
            w_curve = (w_avg_ext >> 1) + EXT_W'(CURVE_OFS_MID);
        else
            w_curve = (w_avg_ext << 1) - EXT_W'(CURVE_OFS_HI);
    end

    assign w_target = (w_curve > MAX_VAL) ? WIDTH'(MAX_VAL) : WIDTH'(w_curve);
`else
    assign w_target = w_avg;
`endif

    // Two extra bits keep prev +/- MAX_STEP from wrapping before the clamp
    assign w_prev_ext   = EXT_W'(i_prev);
    assign w_target_ext = EXT_W'(w_target);
    assign w_up         = w_prev_ext + MAX_STEP_EXT;
    assign w_dn         = (w_prev_ext > MAX_STEP_EXT) ? (w_prev_ext - MAX_STEP_EXT) : '0;

    // NOTE: o_value gets a default before any branch so no latch can be inferred.
    always_comb begin
        o_value = '0;
        if (!i_idle) begin
            if (w_target_ext > w_prev_ext)
                o_value = (w_target_ext < w_up) ? w_target : WIDTH'(w_up);
            else
                o_value = (w_target_ext > w_dn) ? w_target : WIDTH'(w_dn);
        end
    end

endmodule

// File: rtl/multi_channel_rate_limiter.sv
// Multi-channel moving-average rate limiter; one shared shaper serves every channel.
// Optional throttle curve enabled by defining THROTTLE_CURVE_EN.
module multi_channel_rate_limiter
    import multi_channel_rate_limiter_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int CHANNELS       = DEF_CHANNELS,
    parameter int MAX_STEP       = DEF_MAX_STEP,
    parameter int IDLE_THRESHOLD = DEF_IDLE_THRESHOLD
) (
    input  logic                      us_clk,
    input  logic                      resetn,
    input  logic                      start_signal,
    input  logic [CHANNELS*WIDTH-1:0] values_in,
    output logic [CHANNELS*WIDTH-1:0] values_out,
    output logic                      active_signal,
    output logic                      complete_signal
);

    localparam int LOG2D = $clog2(DEPTH);
    localparam int SUM_W = WIDTH + LOG2D;
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    state_t              r_state;
    logic                r_start_q;
    logic                r_start_pulse;
    logic                r_pending;
    logic                r_active;
    logic                r_complete;
    logic [IDX_W-1:0]    r_idx;
    logic [CHANNELS-1:0] r_idle;
    logic [WIDTH-1:0]    r_latched [CHANNELS];
    logic [WIDTH-1:0]    r_buf     [CHANNELS][DEPTH];
    logic [SUM_W-1:0]    r_sum     [CHANNELS];
    logic [LOG2D-1:0]    r_ptr     [CHANNELS];
    logic [WIDTH-1:0]    r_out     [CHANNELS];

    logic             w_req;
    logic             w_last;
    logic             w_new_idle;
    logic [WIDTH-1:0] w_new;
    logic [WIDTH-1:0] w_old;
    logic [WIDTH-1:0] w_shaped;

    assign w_req      = r_start_pulse | r_pending;
    assign w_last     = (r_idx == LAST_IDX);
    assign w_new      = r_latched[r_idx];
    assign w_old      = r_buf[r_idx][r_ptr[r_idx]];
    assign w_new_idle = int'(w_new) < IDLE_THRESHOLD;

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= WAITING;
            r_start_q     <= 1'b0;
            r_start_pulse <= 1'b0;
            r_pending     <= 1'b0;
            r_active      <= 1'b0;
            r_complete    <= 1'b0;
            r_idx         <= '0;
        end else begin
            r_start_q     <= start_signal;
            r_start_pulse <= start_signal & ~r_start_q;
            // A request seen mid-transaction is remembered once; extra ones are dropped
            if (r_start_pulse && (r_state inside {LATCH, ACCUM, SHAPE}))
                r_pending <= 1'b1;
            case (r_state)
                WAITING: begin
                    if (w_req) begin
                        r_state   <= LATCH;
                        r_active  <= 1'b1;
                        r_pending <= 1'b0;
                    end
                end
                LATCH: begin
                    r_state <= ACCUM;
                    r_idx   <= '0;
                end
                ACCUM: begin
                    if (w_last) begin
                        r_state <= SHAPE;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                SHAPE: begin
                    if (w_last) begin
                        r_state    <= COMPLETE;
                        r_idx      <= '0;
                        r_active   <= 1'b0;
                        r_complete <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                COMPLETE: begin
                    r_complete <= 1'b0;
                    if (w_req) begin
                        r_state   <= LATCH;
                        r_active  <= 1'b1;
                        r_pending <= 1'b0;
                    end else begin
                        r_state <= WAITING;
                    end
                end
                default: r_state <= WAITING;
            endcase
        end
    end

    // NOTE: the sample buffers are reset because a restart must see a zeroed window.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            r_idle <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_latched[c] <= '0;
                r_sum[c]     <= '0;
                r_ptr[c]     <= '0;
                r_out[c]     <= '0;
                for (int d = 0; d < DEPTH; d++) r_buf[c][d] <= '0;
            end
        end else begin
            case (r_state)
                LATCH: begin
                    for (int c = 0; c < CHANNELS; c++)
                        r_latched[c] <= values_in[c*WIDTH +: WIDTH];
                end
                ACCUM: begin
                    if (w_new_idle) begin
                        for (int d = 0; d < DEPTH; d++) r_buf[r_idx][d] <= '0;
                        r_sum[r_idx]  <= '0;
                        r_idle[r_idx] <= 1'b1;
                    end else begin
                        r_buf[r_idx][r_ptr[r_idx]] <= w_new;
                        r_sum[r_idx]  <= r_sum[r_idx] - SUM_W'(w_old) + SUM_W'(w_new);
                        r_ptr[r_idx]  <= r_ptr[r_idx] + 1'b1;
                        r_idle[r_idx] <= 1'b0;
                    end
                end
                SHAPE:   r_out[r_idx] <= w_shaped;
                default: ;
            endcase
        end
    end

    rate_limit_shaper #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .MAX_STEP (MAX_STEP)
    ) u_shaper (
        .i_sum   (r_sum[r_idx]),
        .i_prev  (r_out[r_idx]),
        .i_idle  (r_idle[r_idx]),
        .o_value (w_shaped)
    );

    for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
        assign values_out[g*WIDTH +: WIDTH] = r_out[g];
    end

    assign active_signal   = r_active;
    assign complete_signal = r_complete;

endmodule

// File: tb/tb_multi_channel_rate_limiter.sv
// Self-checking bench for multi_channel_rate_limiter: windowed-average reference model
// plus directed pins; curve expectations follow THROTTLE_CURVE_EN.
module tb_multi_channel_rate_limiter;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int CH = 4;
    localparam int MS = 16;
    localparam int IT = 10;
    localparam int VMAX = (1 << W) - 1;

    logic            us_clk = 1'b0;
    logic            resetn = 1'b0;
    logic            start_signal = 1'b0;
    logic [CH*W-1:0] values_in = '0;
    logic [CH*W-1:0] values_out;
    logic            active_signal;
    logic            complete_signal;

    int total = 0;
    int bad   = 0;

    multi_channel_rate_limiter #(
        .WIDTH(W), .DEPTH(D), .CHANNELS(CH), .MAX_STEP(MS), .IDLE_THRESHOLD(IT)
    ) dut (
        .us_clk          (us_clk),
        .resetn          (resetn),
        .start_signal    (start_signal),
        .values_in       (values_in),
        .values_out      (values_out),
        .active_signal   (active_signal),
        .complete_signal (complete_signal)
    );

    always #5 us_clk = ~us_clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [CH*W-1:0] pack(input int a, input int b, input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    function automatic int field(input logic [CH*W-1:0] v, input int c);
        return int'(v[c*W +: W]);
    endfunction

    function automatic int target_of(input int avg);
`ifdef THROTTLE_CURVE_EN
        int t;
        if (avg < 42)        t = 2 * avg;
        else if (avg <= 209) t = avg / 2 + 61;
        else                 t = 2 * avg - 252;
        if (t > VMAX) t = VMAX;
        if (t < 0)    t = 0;
        return t;
`else
        return avg;
`endif
    endfunction

    // ---------------- reference model ----------------
    int m_hist [CH][$];
    int m_exp  [CH];
    int m_next [CH];
    bit m_in_txn = 0, m_pending = 0, m_req = 0, m_prev_start = 0;
    bit m_exp_active = 0, m_exp_complete = 0;
    int m_latch = 0;
    int edge_n  = 0;

    // Result of one transaction: window of the last D non-idle samples (zeros if short)
    task automatic m_compute(input logic [CH*W-1:0] vin);
        for (int c = 0; c < CH; c++) begin
            int v, s, avg, tgt, p, lo;
            v = field(vin, c);
            if (v < IT) begin
                m_hist[c].delete();
                m_next[c] = 0;
            end else begin
                m_hist[c].push_back(v);
                if (m_hist[c].size() > D) void'(m_hist[c].pop_front());
                s = 0;
                foreach (m_hist[c][k]) s += m_hist[c][k];
                avg = s / D;
                tgt = target_of(avg);
                p   = m_exp[c];
                if (tgt > p) m_next[c] = (tgt < p + MS) ? tgt : p + MS;
                else begin
                    lo = (p - MS < 0) ? 0 : p - MS;
                    m_next[c] = (tgt > lo) ? tgt : lo;
                end
            end
        end
    endtask

    // Schedule: LATCH at edge L, inputs captured at L+1, channel c shown at L+CH+2+c,
    // complete during the cycle after edge L+2*CH+1.
    always @(posedge us_clk or negedge resetn) begin : ref_model
        int off;
        bit rise, busy, done, go;
        if (!resetn) begin
            for (int c = 0; c < CH; c++) begin
                m_hist[c].delete();
                m_exp[c]  = 0;
                m_next[c] = 0;
            end
            m_in_txn = 0; m_pending = 0; m_req = 0; m_prev_start = 0;
            m_exp_active = 0; m_exp_complete = 0;
        end else begin
            edge_n++;
            rise = start_signal && !m_prev_start;
            m_prev_start = start_signal;
            off  = edge_n - 1 - m_latch;
            busy = m_in_txn && off >= 0 && off <= 2 * CH;
            done = m_in_txn && off == 2 * CH + 1;
            if (m_req && busy) m_pending = 1;
            go = !busy && (m_req || m_pending);
            if (done && !go) m_in_txn = 0;
            if (go) begin
                m_in_txn  = 1;
                m_latch   = edge_n;
                m_pending = 0;
            end
            off = edge_n - m_latch;
            if (m_in_txn && off == 1) m_compute(values_in);
            for (int c = 0; c < CH; c++)
                if (m_in_txn && off == CH + 2 + c) m_exp[c] = m_next[c];
            m_exp_active   = m_in_txn && off >= 0 && off <= 2 * CH;
            m_exp_complete = m_in_txn && off == 2 * CH + 1;
            m_req = rise;
        end
    end

    always @(negedge us_clk) begin
        check("active", int'(active_signal), int'(m_exp_active));
        check("complete", int'(complete_signal), int'(m_exp_complete));
        for (int c = 0; c < CH; c++)
            check($sformatf("out_ch%0d", c), field(values_out, c), m_exp[c]);
    end

    // ---------------- stimulus ----------------
    task automatic run_txn(input logic [CH*W-1:0] v);
        int n, act;
        bit seen;
        @(negedge us_clk);
        values_in    = v;
        start_signal = 1'b1;
        @(negedge us_clk);
        start_signal = 1'b0;
        n = 0; act = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge us_clk);
            n++;
            if (complete_signal) seen = 1;
            else if (active_signal) act++;
        end
        check("txn_latency", seen ? n : -1, 2 * CH + 2);
        check("txn_active_cycles", act, 2 * CH + 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, first_at, second_at;
        repeat (2) @(negedge us_clk);
        check("reset_out", int'(values_out), 0);
        check("reset_active", int'(active_signal), 0);
        check("reset_complete", int'(complete_signal), 0);
        resetn = 1'b1;

        // Timing with all channels idle
        run_txn(pack(0, 0, 0, 0));

        // ch0 steps to 200; slew limited first, then window-average limited
        for (int k = 0; k < 14; k++) begin
            run_txn(pack(200, 0, 0, 0));
            if (k < 4) check($sformatf("ch0_ramp_%0d", k), field(values_out, 0), 16 * (k + 1));
        end
        check("ch0_settled", field(values_out, 0), 200);
        check("ch123_zero", int'(values_out[CH*W-1:W]), 0);

        // ch1 steady 200, then idle drop and fresh restart
        for (int k = 0; k < 20; k++) run_txn(pack(0, 200, 0, 0));
        check("ch1_steady", field(values_out, 1), 200);
        run_txn(pack(0, 5, 0, 0));
        check("ch1_idle_zero", field(values_out, 1), 0);
        run_txn(pack(0, 100, 0, 0));
        check("ch1_restart", field(values_out, 1), 12);

        // Steady 30/100/230
        for (int k = 0; k < 30; k++) run_txn(pack(30, 100, 230, 0));
`ifdef THROTTLE_CURVE_EN
        check("curve_ch0", field(values_out, 0), 60);
        check("curve_ch1", field(values_out, 1), 111);
        check("curve_ch2", field(values_out, 2), 208);
`else
        check("flat_ch0", field(values_out, 0), 30);
        check("flat_ch1", field(values_out, 1), 100);
        check("flat_ch2", field(values_out, 2), 230);
`endif

        // One pending request plus one dropped edge -> two completes, 10 edges apart
        @(negedge us_clk);
        start_signal = 1'b1;
        @(negedge us_clk);
        start_signal = 1'b0;
        cnt = 0; first_at = -1; second_at = -1;
        for (n = 1; n <= 40; n++) begin
            @(negedge us_clk);
            start_signal = (n == 3 || n == 6);
            if (complete_signal) begin
                cnt++;
                if (cnt == 1) first_at = n;
                if (cnt == 2) second_at = n;
            end
        end
        check("pending_count", cnt, 2);
        check("pending_first", first_at, 10);
        check("pending_second", second_at, 20);

        // Reset during ch2's SHAPE cycle
        @(negedge us_clk);
        values_in    = pack(120, 140, 160, 180);
        start_signal = 1'b1;
        @(negedge us_clk);
        start_signal = 1'b0;
        repeat (8) @(negedge us_clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst_out", int'(values_out), 0);
        check("midrst_active", int'(active_signal), 0);
        cnt = 0;
        repeat (2) begin
            @(negedge us_clk);
            if (complete_signal) cnt++;
        end
        resetn = 1'b1;
        repeat (15) begin
            @(negedge us_clk);
            if (complete_signal) cnt++;
        end
        check("midrst_no_complete", cnt, 0);
        run_txn(pack(200, 0, 0, 0));
        check("post_rst_ch0", field(values_out, 0), 16);

        // Randomized: arbitrary start toggling and input changes, model tracks all of it
        for (int k = 0; k < 600; k++) begin
            @(negedge us_clk);
            if ($urandom_range(0, 4) == 0) start_signal = ~start_signal;
            if ($urandom_range(0, 3) == 0) begin
                for (int c = 0; c < CH; c++)
                    values_in[c*W +: W] = ($urandom_range(0, 4) == 0) ? W'($urandom_range(0, IT - 1))
                                                                      : W'($urandom_range(0, VMAX));
            end
        end
        start_signal = 1'b0;
        repeat (30) @(negedge us_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
